// File: rtl/cic_pkg.sv
// Shared definitions for the microphone front end and the per-channel delay
// line downstream of it: PCM word width, CIC shape and the PCM sample type.
package cic_pkg;

  localparam int PCM_W      = 19;
  localparam int CIC_ORDER  = 3;
  localparam int CIC_DECIM  = 64;
  // Raw CIC output is unsigned in [0, 2^18]; subtracting the mid-point
  // centres it around zero.
  localparam int PCM_OFFSET = 2**17;

  typedef logic signed [PCM_W-1:0] pcm_t;

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PCM sample stream from the decimator to its consumer.
//   pcm_data  : signed PCM word, held between strobes
//   pcm_valid : one-cycle strobe marking a new pcm_data word
// master = producer (decimator), slave = consumer (delay line).
interface pdm_cic_decimator_if;
  import cic_pkg::*;

  pcm_t pcm_data;
  logic pcm_valid;

  modport master (output pcm_data, output pcm_valid);
  modport slave  (input  pcm_data, input  pcm_valid);

endinterface

// File: rtl/pdm_cic_decimator_clk_gen.sv
// Microphone clock generator.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   pdm_clk    : 50% duty microphone clock, period 2*CLK_HALF clk cycles
//   sample_stb : high in the last clk cycle of each pdm_clk high phase,
//                i.e. the cycle whose closing edge takes pdm_clk low
module pdm_clk_gen #(
  parameter int CLK_HALF = 25
) (
  input  logic clk,
  input  logic rst,
  output logic pdm_clk,
  output logic sample_stb
);

  localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  logic [CW-1:0] half_cnt;
  logic          half_wrap;

  assign half_wrap = (half_cnt == CW'(CLK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
      pdm_clk  <= 1'b0;
    end else if (half_wrap) begin
      half_cnt <= '0;
      pdm_clk  <= ~pdm_clk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // The data bit has had the whole high phase to settle through the
  // synchroniser, so it is taken just as pdm_clk falls.
  assign sample_stb = half_wrap & pdm_clk;

endmodule

// File: rtl/pdm_cic_decimator.sv
// One microphone channel: generates pdm_clk, synchronises the 1-bit PDM
// stream and decimates it with an ORDER-stage CIC into signed PCM.
//   clk       : system clock (single domain)
//   rst       : synchronous active-high reset; discards any partial frame
//   pdm_data  : PDM bit from the microphone, asynchronous to clk
//   pdm_clk   : microphone clock
//   pcm       : master side of the PCM stream (pcm_data / pcm_valid)
// pcm_valid is held low for the first ORDER outputs after reset while the
// comb delays fill; pcm_data keeps updating during that time.
module pdm_cic_decimator
  import cic_pkg::*;
#(
  parameter int CLK_HALF = 25,
  parameter int DECIM    = CIC_DECIM,
  parameter int ORDER    = CIC_ORDER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdm_data,
  output logic                  pdm_clk,
  pdm_cic_decimator_if.master   pcm
);

  localparam int DW = $clog2(DECIM);

  logic          sample_stb;
  logic          pdm_sync_p0;
  logic          pdm_sync_p1;
  logic [DW-1:0] dcnt;
  logic          frm_p0;
  logic [1:0]    warm;

  pcm_t integ     [ORDER];
  pcm_t integ_nxt [ORDER];
  pcm_t cdly      [ORDER];
  pcm_t comb_val  [ORDER+1];

  // Re-centre the unsigned CIC result; its range [0, 2^18] maps exactly
  // onto [-2^17, +2^17], so no clipping is ever needed.
  function automatic pcm_t to_pcm(input pcm_t y);
    return y - pcm_t'(PCM_OFFSET);
  endfunction

  pdm_clk_gen #(.CLK_HALF(CLK_HALF)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .pdm_clk    (pdm_clk),
    .sample_stb (sample_stb)
  );

  // Integrators chain within one sample so the newest bit is part of the
  // frame it closes; combs take the registered last integrator. All sums
  // wrap modulo 2^PCM_W on purpose: the comb differences undo the wrap.
  always_comb begin
    integ_nxt[0] = integ[0] + {{(PCM_W-1){1'b0}}, pdm_sync_p1};
    for (int i = 1; i < ORDER; i++)
      integ_nxt[i] = integ[i] + integ_nxt[i-1];
    comb_val[0] = integ[ORDER-1];
    for (int i = 0; i < ORDER; i++)
      comb_val[i+1] = comb_val[i] - cdly[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_sync_p0   <= 1'b0;
      pdm_sync_p1   <= 1'b0;
      dcnt          <= '0;
      frm_p0        <= 1'b0;
      warm          <= '0;
      for (int i = 0; i < ORDER; i++) begin
        integ[i] <= '0;
        cdly[i]  <= '0;
      end
      pcm.pcm_data  <= '0;
      pcm.pcm_valid <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser on the asynchronous PDM bit
      pdm_sync_p0 <= pdm_data;
      pdm_sync_p1 <= pdm_sync_p0;

      // Stage p0: integrate at the input rate, flag the frame-closing sample
      frm_p0 <= sample_stb && (dcnt == DW'(DECIM - 1));
      if (sample_stb) begin
        dcnt <= dcnt + 1'b1;
        for (int i = 0; i < ORDER; i++)
          integ[i] <= integ_nxt[i];
      end

      // Stage p1: combs at the decimated rate and the output register
      pcm.pcm_valid <= 1'b0;
      if (frm_p0) begin
        for (int i = 0; i < ORDER; i++)
          cdly[i] <= comb_val[i];
        pcm.pcm_data  <= to_pcm(comb_val[ORDER]);
        pcm.pcm_valid <= (warm == 2'(ORDER));
        if (warm != 2'(ORDER))
          warm <= warm + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator. A short pdm_clk half period
// keeps the run small; all timing expectations derive from it. The golden
// model is a direct convolution of the sampled bits with the CIC impulse
// response (box filter convolved with itself ORDER times).
module tb_pdm_cic_decimator;
  import cic_pkg::*;

  localparam int CH   = 3;
  localparam int PER  = 2*CH;
  localparam int FR   = CIC_DECIM*PER;
  localparam int HLEN = CIC_ORDER*CIC_DECIM - (CIC_ORDER - 1);

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic pdm_data = 1'b0;
  logic pdm_clk;

  pdm_cic_decimator_if u_if ();

  pdm_cic_decimator #(.CLK_HALF(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .pdm_data (pdm_data),
    .pdm_clk  (pdm_clk),
    .pcm      (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;         // 0 const0, 1 const1, 2 alternating, 3 step, 4 random
    int frames;
    int steady_from;  // first frame index held to steady_val (0 = none)
    int steady_val;
    bit mono;         // outputs must be non-decreasing
  } vec_t;

  vec_t vecs [4];

  int checks   = 0;
  int failures = 0;
  int t;
  int nbits;
  int h [HLEN];
  bit hist [8192];
  int prev_pcm;
  int steady_from;
  int steady_val;
  bit mono;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, expv);
    end
  endtask

  function automatic int model(input int m);
    int y = 0;
    for (int j = 0; j < HLEN; j++)
      if (m - 1 - j >= 0) y += h[j] * int'(hist[m-1-j]);
    return y - PCM_OFFSET;
  endfunction

  function automatic bit gen_bit(input int mode, input int n);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (n % 2 == 0);
      3:       return (n >= 5*CIC_DECIM);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clk cycle: check outputs against the expected waveform, then drive
  // the next PDM bit just after each pdm_clk rise.
  task automatic step(input int mode);
    int k, act, expv;
    @(posedge clk);
    #1;
    t++;
    chk("pdm_clk", int'(pdm_clk), (t / CH) % 2);
    chk("pcm_valid", int'(u_if.pcm_valid), int'((t % FR == 1) && (t / FR >= 4)));
    if ((t % FR == 1) && (t / FR >= 1)) begin
      k    = t / FR;
      act  = int'(u_if.pcm_data);
      expv = model(k*CIC_DECIM);
      chk("pcm_model", act, expv);
      if (steady_from > 0 && k >= steady_from) chk("pcm_steady", act, steady_val);
      if (mono && k >= 2) chk("pcm_monotonic", int'(act >= prev_pcm), 1);
      prev_pcm = act;
    end
    if (t % PER == CH) begin
      pdm_data    = gen_bit(mode, nbits);
      hist[nbits] = pdm_data;
      nbits++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    pdm_data = 1'b0;
    t        = 0;
    nbits    = 0;
    chk("rst_pdm_clk", int'(pdm_clk), 0);
    chk("rst_pcm_valid", int'(u_if.pcm_valid), 0);
    chk("rst_pcm_data", int'(u_if.pcm_data), 0);
  endtask

  initial begin
    int a [HLEN];
    int b [HLEN];

    for (int i = 0; i < HLEN; i++) a[i] = (i < CIC_DECIM) ? 1 : 0;
    for (int s = 1; s < CIC_ORDER; s++) begin
      for (int i = 0; i < HLEN; i++) b[i] = 0;
      for (int i = 0; i < HLEN; i++)
        for (int j = 0; j < CIC_DECIM; j++)
          if (i + j < HLEN) b[i+j] += a[i];
      a = b;
    end
    h = a;

    vecs[0] = '{1,  6, 4,  131072, 1'b0};
    vecs[1] = '{0,  6, 4, -131072, 1'b0};
    vecs[2] = '{2,  6, 4,       0, 1'b0};
    vecs[3] = '{3, 10, 8,  131072, 1'b1};

    for (int v = 0; v < 4; v++) begin
      steady_from = vecs[v].steady_from;
      steady_val  = vecs[v].steady_val;
      mono        = vecs[v].mono;
      do_reset();
      repeat (FR*vecs[v].frames + 2) step(vecs[v].mode);
    end

    steady_from = 0;
    mono        = 1'b0;
    do_reset();
    repeat (FR*100 + 2) step(4);

    // Reset mid-frame while pdm_clk is high and warm-up is complete; the
    // following run must suppress its first three outputs again.
    steady_from = 4;
    steady_val  = 131072;
    do_reset();
    repeat (FR*5 + FR/2 + 3) step(1);
    chk("pre_rst_pdm_clk_high", int'(pdm_clk), 1);
    do_reset();
    repeat (FR*5 + 2) step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
